// File: rtl/alu_8bit_pkg.sv
// Shared definitions for the 8-bit ALU and its downstream stages:
// opcode encodings and the packed result entry carried through buffers.
package alu_8bit_pkg;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_RSUB = 3'b010;
  localparam logic [2:0] OP_OR   = 3'b011;
  localparam logic [2:0] OP_AND  = 3'b100;
  localparam logic [2:0] OP_XOR  = 3'b101;
  localparam logic [2:0] OP_XNOR = 3'b110;
  localparam logic [2:0] OP_NOP  = 3'b111;

  typedef struct packed {
    logic [7:0] sum;
    logic [2:0] oper;
    logic       zero;
    logic       neg;
    logic       parity;
  } result_entry_t;

endpackage

// File: rtl/alu_result_flags.sv
// Combinational status flags for an 8-bit ALU result; parity is 1 when the
// number of set bits is odd.
module alu_result_flags (
  input  logic [7:0] sum,
  output logic       zero,
  output logic       neg,
  output logic       parity
);

  assign zero   = (sum == 8'h00);
  assign neg    = sum[7];
  assign parity = ^sum;

endmodule

// File: rtl/alu_8bit_result_stage.sv
// Registered ALU output stage: 2-entry skid buffer with per-entry flags,
// plus a wrapping transfer counter and a saturating result accumulator.
module alu_8bit_result_stage
  import alu_8bit_pkg::*;
#(
  parameter int ACC_W    = 16,
  parameter int CNT_W    = 8,
  parameter bit DROP_NOP = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_sum,
  input  logic [2:0]       in_oper,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_sum,
  output logic [2:0]       out_oper,
  output logic             out_zero,
  output logic             out_neg,
  output logic             out_parity,
  input  logic             acc_clr,
  output logic [ACC_W-1:0] acc,
  output logic [CNT_W-1:0] cnt
);

  result_entry_t    main_reg;
  result_entry_t    skid_reg;
  result_entry_t    in_entry;
  logic             main_valid_reg;
  logic             skid_valid_reg;
  logic             accept;
  logic             store;
  logic             xfer;
  logic             in_zero;
  logic             in_neg;
  logic             in_parity;
  logic [ACC_W:0]   acc_sum;
  logic [ACC_W-1:0] acc_reg;
  logic [CNT_W-1:0] cnt_reg;

  alu_result_flags u_flags (
    .sum    (in_sum),
    .zero   (in_zero),
    .neg    (in_neg),
    .parity (in_parity)
  );

  assign in_entry = '{sum: in_sum, oper: in_oper, zero: in_zero, neg: in_neg, parity: in_parity};

  // in_ready depends only on skid occupancy, so out_ready never reaches it combinationally.
  assign in_ready = !skid_valid_reg;
  assign accept   = in_valid && !skid_valid_reg;
  assign store    = accept && !(DROP_NOP && (in_oper == OP_NOP));
  assign xfer     = main_valid_reg && out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_valid_reg <= 1'b0;
      skid_valid_reg <= 1'b0;
      main_reg       <= '0;
      skid_reg       <= '0;
    end else if (skid_valid_reg) begin
      if (xfer) begin
        main_reg       <= skid_reg;
        skid_valid_reg <= 1'b0;
      end
    end else if (main_valid_reg) begin
      if (store && xfer) begin
        main_reg <= in_entry;
      end else if (store) begin
        skid_reg       <= in_entry;
        skid_valid_reg <= 1'b1;
      end else if (xfer) begin
        main_valid_reg <= 1'b0;
      end
    end else if (store) begin
      main_reg       <= in_entry;
      main_valid_reg <= 1'b1;
    end
  end

  assign acc_sum = {1'b0, acc_reg} + {{(ACC_W-7){1'b0}}, main_reg.sum};

  // A clear coinciding with a transfer restarts the tallies at that transfer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_reg <= '0;
      cnt_reg <= '0;
    end else if (acc_clr) begin
      acc_reg <= xfer ? {{(ACC_W-8){1'b0}}, main_reg.sum} : '0;
      cnt_reg <= xfer ? CNT_W'(1) : '0;
    end else if (xfer) begin
      acc_reg <= acc_sum[ACC_W] ? '1 : acc_sum[ACC_W-1:0];
      cnt_reg <= cnt_reg + CNT_W'(1);
    end
  end

  assign out_valid  = main_valid_reg;
  assign out_sum    = main_reg.sum;
  assign out_oper   = main_reg.oper;
  assign out_zero   = main_reg.zero;
  assign out_neg    = main_reg.neg;
  assign out_parity = main_reg.parity;
  assign acc        = acc_reg;
  assign cnt        = cnt_reg;

endmodule

// File: tb/tb_alu_8bit_result_stage.sv
// Scoreboard bench for alu_8bit_result_stage: a driver queues expected results,
// a negedge monitor compares every transfer and tracks acc/cnt with plain arithmetic.
module tb_alu_8bit_result_stage;
  import alu_8bit_pkg::*;

  localparam int ACC_W = 16;
  localparam int CNT_W = 8;
  localparam longint ACC_MAX = (64'd1 << ACC_W) - 1;

  typedef struct {
    logic [7:0] sum;
    logic [2:0] oper;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0, in_valid_k = 1'b0;
  logic [7:0] in_sum = '0;
  logic [2:0] in_oper = '0;
  logic out_ready = 1'b0, acc_clr = 1'b0;
  logic in_ready, out_valid, out_zero, out_neg, out_parity;
  logic [7:0] out_sum;
  logic [2:0] out_oper;
  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic in_ready_k, out_valid_k, out_zero_k, out_neg_k, out_parity_k;
  logic [7:0] out_sum_k;
  logic [2:0] out_oper_k;
  logic [ACC_W-1:0] acc_k;
  logic [CNT_W-1:0] cnt_k;

  int checks = 0, errors = 0;
  exp_t exp_q[$];
  exp_t exp_k[$];
  longint model_acc = 0, model_cnt = 0;
  bit rand_mode = 1'b0;

  always #5 clk = ~clk;

  alu_8bit_result_stage #(.ACC_W(ACC_W), .CNT_W(CNT_W), .DROP_NOP(1'b1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_sum(in_sum),
    .in_oper(in_oper), .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
    .out_oper(out_oper), .out_zero(out_zero), .out_neg(out_neg), .out_parity(out_parity),
    .acc_clr(acc_clr), .acc(acc), .cnt(cnt));

  alu_8bit_result_stage #(.ACC_W(ACC_W), .CNT_W(CNT_W), .DROP_NOP(1'b0)) dut_keep (
    .clk(clk), .rst(rst), .in_valid(in_valid_k), .in_ready(in_ready_k), .in_sum(in_sum),
    .in_oper(in_oper), .out_valid(out_valid_k), .out_ready(out_ready), .out_sum(out_sum_k),
    .out_oper(out_oper_k), .out_zero(out_zero_k), .out_neg(out_neg_k), .out_parity(out_parity_k),
    .acc_clr(acc_clr), .acc(acc_k), .cnt(cnt_k));

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard for the dropping instance, plus the acc/cnt reference model.
  always @(negedge clk) begin
    if (!rst) begin
      exp_t e;
      logic xfer;
      longint s;
      check("acc", acc, model_acc);
      check("cnt", cnt, model_cnt);
      xfer = out_valid && out_ready;
      s = 0;
      if (xfer) begin
        if (exp_q.size() == 0) begin
          check("unexpected_output", out_sum, -1);
        end else begin
          e = exp_q.pop_front();
          s = e.sum;
          check("out_sum", out_sum, e.sum);
          check("out_oper", out_oper, e.oper);
          check("out_zero", out_zero, (e.sum == 0) ? 1 : 0);
          check("out_neg", out_neg, (e.sum >= 8'd128) ? 1 : 0);
          check("out_parity", out_parity, $countones(e.sum) % 2);
        end
      end
      if (acc_clr) begin
        model_acc = xfer ? s : 0;
        model_cnt = xfer ? 1 : 0;
      end else if (xfer) begin
        model_acc = (model_acc + s > ACC_MAX) ? ACC_MAX : model_acc + s;
        model_cnt = (model_cnt + 1) % (1 << CNT_W);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && out_valid_k && out_ready) begin
      exp_t e;
      if (exp_k.size() == 0) begin
        check("keep_unexpected_output", out_sum_k, -1);
      end else begin
        e = exp_k.pop_front();
        check("keep_out_sum", out_sum_k, e.sum);
        check("keep_out_oper", out_oper_k, e.oper);
      end
    end
  end

  always @(posedge clk) begin
    if (rand_mode) begin
      #1;
      out_ready = ($urandom_range(0, 3) != 0);
      acc_clr   = ($urandom_range(0, 15) == 0);
    end
  end

  // Holds the item on the inputs until it is accepted, then records what must emerge.
  task automatic push(input logic [7:0] s, input logic [2:0] o, input bit both);
    int waitc = 0;
    exp_t e;
    e.sum = s;
    e.oper = o;
    @(posedge clk); #1;
    in_valid = 1'b1; in_valid_k = both; in_sum = s; in_oper = o;
    while (!in_ready && waitc < 200) begin
      waitc++;
      @(posedge clk); #1;
    end
    if (!in_ready) begin
      check("push_timeout", 0, 1);
    end else begin
      if (o != OP_NOP) exp_q.push_back(e);
      if (both) begin
        check("keep_in_ready", in_ready_k, 1);
        exp_k.push_back(e);
      end
    end
  endtask

  task automatic idle();
    @(posedge clk); #1;
    in_valid = 1'b0; in_valid_k = 1'b0;
    in_sum = 8'($urandom); in_oper = 3'($urandom);
  endtask

  task automatic drain();
    int waitc = 0;
    out_ready = 1'b1;
    while ((exp_q.size() != 0 || exp_k.size() != 0 || out_valid) && waitc < 100) begin
      waitc++;
      @(posedge clk); #1;
    end
    check("drain_done", (exp_q.size() == 0 && exp_k.size() == 0 && !out_valid) ? 1 : 0, 1);
    @(posedge clk); #1;
  endtask

  task automatic clear_acc();
    @(posedge clk); #1; acc_clr = 1'b1;
    @(posedge clk); #1; acc_clr = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int stalls;
    longint c0;
    repeat (3) @(posedge clk);
    #3 rst = 1'b0;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_sum", out_sum, 0);
    check("rst_out_oper", out_oper, 0);
    check("rst_flags", {out_zero, out_neg, out_parity}, 0);
    check("rst_acc", acc, 0);
    check("rst_cnt", cnt, 0);

    // Single pass: 0x80 from SUB.
    out_ready = 1'b1;
    push(8'h80, OP_SUB, 1'b0);
    idle();
    check("pass_out_valid", out_valid, 1);
    check("pass_out_sum", out_sum, 8'h80);
    check("pass_neg", out_neg, 1);
    check("pass_zero", out_zero, 0);
    check("pass_parity", out_parity, 1);
    @(posedge clk); #1;
    check("pass_cnt", cnt, 1);
    check("pass_acc", acc, 16'h0080);

    // Back-pressure: third push must stall until the consumer drains.
    out_ready = 1'b0;
    push(8'h00, OP_ADD, 1'b0);
    push(8'h05, OP_XOR, 1'b0);
    @(posedge clk); #1;
    in_valid = 1'b1; in_sum = 8'h07; in_oper = OP_OR;
    check("bp_in_ready_full", in_ready, 0);
    repeat (2) @(posedge clk);
    #1;
    check("bp_in_ready_hold", in_ready, 0);
    out_ready = 1'b1;
    push(8'h07, OP_OR, 1'b0);
    idle();
    drain();

    // Full throughput with saturation and counter wrap.
    clear_acc();
    stalls = 0;
    for (int i = 0; i < 300; i++) begin
      exp_t e;
      @(posedge clk); #1;
      in_valid = 1'b1; in_sum = 8'hFF; in_oper = OP_ADD;
      if (!in_ready) stalls++;
      else begin
        e.sum = 8'hFF; e.oper = OP_ADD;
        exp_q.push_back(e);
      end
    end
    idle();
    drain();
    check("tput_stalls", stalls, 0);
    check("tput_cnt", cnt, 44);
    check("tput_acc", acc, 16'hFFFF);

    // NOP handling: dropped by one instance, kept by the other.
    c0 = cnt;
    push(8'h55, OP_NOP, 1'b1);
    push(8'h11, OP_ADD, 1'b1);
    idle();
    drain();
    check("nop_cnt_delta", (cnt - c0) % 256, 1);
    check("nop_keep_cnt", cnt_k, 2);

    // Clear colliding with a transfer, then clear alone with data held.
    clear_acc();
    push(8'h80, OP_ADD, 1'b0);
    push(8'h80, OP_ADD, 1'b0);
    idle();
    drain();
    check("clr_pre_acc", acc, 16'h0100);
    out_ready = 1'b0;
    push(8'h22, OP_AND, 1'b0);
    push(8'h33, OP_XNOR, 1'b0);
    idle();
    out_ready = 1'b1; acc_clr = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0; acc_clr = 1'b0;
    check("clr_xfer_acc", acc, 16'h0022);
    check("clr_xfer_cnt", cnt, 1);
    clear_acc();
    check("clr_acc", acc, 0);
    check("clr_cnt", cnt, 0);
    check("clr_buf_valid", out_valid, 1);
    check("clr_buf_sum", out_sum, 8'h33);
    drain();

    // Randomized traffic with random back-pressure and clears.
    rand_mode = 1'b1;
    for (int i = 0; i < 200; i++) begin
      int gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) idle();
      push(8'($urandom), 3'($urandom_range(0, 7)), 1'b0);
    end
    idle();
    rand_mode = 1'b0;
    @(posedge clk); #2;
    acc_clr = 1'b0;
    drain();

    // Asynchronous reset while FULL.
    out_ready = 1'b0;
    push(8'hA5, OP_ADD, 1'b0);
    push(8'h5A, OP_SUB, 1'b0);
    idle();
    check("full_in_ready", in_ready, 0);
    #2 rst = 1'b1;
    #1;
    exp_q.delete(); exp_k.delete();
    model_acc = 0; model_cnt = 0;
    check("arst_out_valid", out_valid, 0);
    check("arst_in_ready", in_ready, 1);
    check("arst_acc", acc, 0);
    check("arst_cnt", cnt, 0);
    check("arst_out_sum", out_sum, 0);
    @(posedge clk); #3 rst = 1'b0;
    out_ready = 1'b1;
    push(8'h80, OP_SUB, 1'b0);
    idle();
    check("post_out_valid", out_valid, 1);
    check("post_out_sum", out_sum, 8'h80);
    check("post_neg", out_neg, 1);
    check("post_parity", out_parity, 1);
    @(posedge clk); #1;
    check("post_cnt", cnt, 1);
    check("post_acc", acc, 16'h0080);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_8bit_result_stage.md
Name: alu_8bit_result_stage

Overview:
Registered output stage directly downstream of the combinational 8-bit ALU. It accepts each ALU result (sum plus the opcode that produced it) over a valid/ready handshake and buffers it in a 2-entry skid buffer, so the ALU path is cut from downstream back-pressure. Each result is tagged with zero/negative/parity flags. The stage keeps a transfer counter and a saturating running accumulator for debug and benchmark checksums.

Parameters:
ACC_W, 16, width of the running accumulator (ACC_W >= 9)
CNT_W, 8, width of the transfer counter (wraps)
DROP_NOP, 1, when 1, inputs with in_oper == 3'b111 (ALU default/zero path) are accepted but discarded

Ports:
clk  input  1  single clock, rising edge
rst  input  1  asynchronous reset, active-high
in_valid  input  1  ALU result valid
in_ready  output  1  stage can accept a result this cycle
in_sum  input  8  ALU result
in_oper  input  3  opcode that produced in_sum
out_valid  output  1  buffered result available
out_ready  input  1  consumer accepts out_* this cycle
out_sum  output  8  buffered result
out_oper  output  3  buffered opcode
out_zero  output  1  out_sum == 0
out_neg  output  1  out_sum[7]
out_parity  output  1  XOR-reduce of out_sum (1 = odd)
acc_clr  input  1  synchronous clear of acc and cnt
acc  output  ACC_W  saturating sum of transferred out_sum values
cnt  output  CNT_W  number of output transfers, modulo 2^CNT_W

Behaviour:
- Reset (asynchronous, any time, including mid-transfer): both buffer entries invalid, out_valid=0, in_ready=1, out_sum=0, out_oper=0, all flags 0, acc=0, cnt=0. Buffered data is lost.
- Accept: in_valid && in_ready. Transfer: out_valid && out_ready.
- in_ready is a register output, = !skid_valid. No combinational path from out_ready to in_ready.
- Flags are computed from in_sum at accept time and stored with the entry. Outputs come straight from registers.
- Latency: an accepted result appears on out_* the next cycle when main is empty or is being drained in the same cycle.
- State (skid_valid, main_valid):
  - EMPTY (0,0): accept -> ONE.
  - ONE (0,1): transfer without accept -> EMPTY. Accept with transfer -> ONE with new data. Accept without transfer -> new data to skid -> FULL.
  - FULL (1,1): in_ready=0. Transfer -> skid moves to main -> ONE. Otherwise hold.
- Order is strictly FIFO. No entry is ever overwritten while valid.
- DROP_NOP=1 with in_oper==3'b111: the handshake completes normally, but no entry is written and state is unchanged. With DROP_NOP=0 the input is buffered like any other.
- Accumulator, updated on each transfer: acc <= min(acc + out_sum, 2^ACC_W-1). out_sum is zero-extended and the result saturates, no wrap.
- Counter, updated on each transfer: cnt <= cnt + 1. It wraps from 2^CNT_W-1 to 0.
- acc_clr=1 without transfer: acc=0, cnt=0.
- acc_clr=1 with a simultaneous transfer: acc=out_sum, cnt=1 (clear first, then count this transfer).
- acc_clr does not affect the buffer.
- in_sum and in_oper are ignored when in_valid=0. X on them must not propagate into state.

Decomposition:
- Shared package alu_8bit_pkg: opcode constants (OP_ADD=3'b000, OP_SUB=3'b001, OP_RSUB=3'b010, OP_OR=3'b011, OP_AND=3'b100, OP_XOR=3'b101, OP_XNOR=3'b110, OP_NOP=3'b111) and a packed result-entry typedef {sum[7:0], oper[2:0], zero, neg, parity}. The ALU and this stage both use the package.
- One sub-module: alu_result_flags, a combinational block taking sum[7:0] and producing zero/neg/parity, reusable by other ALU stages.
- The skid buffer, accumulator and counter stay inline.

Test Plan:
- Reset and single pass: after rst, push in_sum=8'h80, oper=OP_SUB with out_ready=1 -> next cycle out_valid=1, out_sum=80, neg=1, zero=0, parity=1; then cnt=1, acc=16'h0080.
- Back-pressure: out_ready=0, push 8'h00, 8'h05, 8'h07 on consecutive cycles -> third push sees in_ready=0 and holds. Release out_ready -> outputs 00 (zero=1), 05 (parity=0), 07 (parity=1) in order, none lost or duplicated.
- Full throughput: in_valid=out_ready=1 for 300 cycles with in_sum=8'hFF -> one transfer per cycle, in_ready stays 1, cnt wraps to 300 mod 256 = 44, acc saturates at 16'hFFFF.
- NOP drop: DROP_NOP=1, push oper=OP_NOP sum=8'h55, then OP_ADD sum=8'h11 -> only 11 emerges, cnt increments by 1. With DROP_NOP=0 both emerge.
- Clear collision: acc=16'h0100, assert acc_clr in the same cycle as a transfer of 8'h22 -> acc=16'h0022, cnt=1. acc_clr alone -> acc=0, cnt=0, buffer contents intact.
- Async reset mid-operation: FULL state with out_ready=0, assert rst between clock edges -> out_valid drops immediately, in_ready=1, acc=0. The first post-reset push behaves as in the first scenario.
